// File: rtl/lmmi_pkg.sv
// Shared types and defaults for the PLL LMMI initiator.
package lmmi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      RDWAIT = 2'd2,
      RSP    = 2'd3
   } lmmi_state_t;

   localparam int         LMMI_OFFSET_W       = 7;
   localparam int         LMMI_DATA_W         = 8;
   localparam int         LMMI_TIMEOUT_CYCLES = 255;
   localparam logic [7:0] LMMI_ERR_RDATA      = 8'hFF;

   // Counter must hold TIMEOUT_CYCLES; keep at least one bit when disabled.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pll_lmmi_initiator.sv
// Host-side LMMI initiator: one register read/write at a time towards the PLL,
// with a bounded wait and a registered valid/ready response.
module pll_lmmi_initiator
   import lmmi_pkg::*;
#(
   parameter int                OFFSET_W       = LMMI_OFFSET_W,
   parameter int                DATA_W         = LMMI_DATA_W,
   parameter int                TIMEOUT_CYCLES = LMMI_TIMEOUT_CYCLES,
   parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(LMMI_ERR_RDATA)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_write_i,
   input  logic [OFFSET_W-1:0] cmd_offset_i,
   input  logic [DATA_W-1:0]   cmd_wdata_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                lmmi_resetn_o,
   output logic                lmmi_request_o,
   output logic                lmmi_wrrd_n_o,
   output logic [OFFSET_W-1:0] lmmi_offset_o,
   output logic [DATA_W-1:0]   lmmi_wdata_o,
   input  logic [DATA_W-1:0]   lmmi_rdata_i,
   input  logic                lmmi_rdata_valid_i,
   input  logic                lmmi_ready_i,
   output logic                spurious_o
);

   localparam int             CNT_W   = cnt_width(TIMEOUT_CYCLES);
   localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   lmmi_state_t         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                resetn_q;
   logic                request_q, request_d;
   logic                wrrd_n_q, wrrd_n_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                spurious_q, spurious_d;
   logic                timeout_hit;
   logic [CNT_W-1:0]    cnt_inc;

   // ">=" so a read whose handshake lands on the last cycle still times out
   // from RDWAIT once the counter has moved past TO_LAST.
   assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);
   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      wrrd_n_d    = wrrd_n_q;
      offset_d    = offset_q;
      wdata_d     = wdata_q;
      spurious_d  = spurious_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               wrrd_n_d = cmd_write_i;
               offset_d = cmd_offset_i;
               wdata_d  = cmd_wdata_i;
               cnt_d    = '0;
               state_d  = REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_inc;
            if (lmmi_ready_i) begin
               if (wrrd_n_q) begin
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b0;
                  state_d     = RSP;
               end else if (lmmi_rdata_valid_i) begin
                  rsp_rdata_d = lmmi_rdata_i;
                  rsp_err_d   = 1'b0;
                  state_d     = RSP;
               end else begin
                  state_d = RDWAIT;
               end
            end else if (timeout_hit) begin
               rsp_rdata_d = ERR_RDATA;
               rsp_err_d   = 1'b1;
               state_d     = RSP;
            end
         end
         RDWAIT: begin
            cnt_d = cnt_inc;
            if (lmmi_rdata_valid_i) begin
               rsp_rdata_d = lmmi_rdata_i;
               rsp_err_d   = 1'b0;
               state_d     = RSP;
            end else if (timeout_hit) begin
               rsp_rdata_d = ERR_RDATA;
               rsp_err_d   = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_valid_q && rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (lmmi_rdata_valid_i &&
          ((state_q == IDLE) || (state_q == RSP) || ((state_q == REQ) && wrrd_n_q)))
         spurious_d = 1'b1;

      // Handshake outputs are registered copies of the next state.
      cmd_ready_d = (state_d == IDLE);
      request_d   = (state_d == REQ);
      rsp_valid_d = (state_d == RSP);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         resetn_q    <= 1'b0;
         request_q   <= 1'b0;
         wrrd_n_q    <= 1'b0;
         offset_q    <= '0;
         wdata_q     <= '0;
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         resetn_q    <= 1'b1;
         request_q   <= request_d;
         wrrd_n_q    <= wrrd_n_d;
         offset_q    <= offset_d;
         wdata_q     <= wdata_d;
         spurious_q  <= spurious_d;
      end
   end

   assign cmd_ready_o    = cmd_ready_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_rdata_o    = rsp_rdata_q;
   assign rsp_err_o      = rsp_err_q;
   assign lmmi_resetn_o  = resetn_q;
   assign lmmi_request_o = request_q;
   assign lmmi_wrrd_n_o  = wrrd_n_q;
   assign lmmi_offset_o  = offset_q;
   assign lmmi_wdata_o   = wdata_q;
   assign spurious_o     = spurious_q;

endmodule

// File: doc/pll_lmmi_initiator.md
Name: pll_lmmi_initiator

Overview:
- LMMI initiator (host side) driving the PLL primitive's LMMI register port: LMMIREQUEST, LMMIWRRD_N, LMMIOFFSET[6:0], LMMIWDATA[7:0], LMMIRDATA[7:0], LMMIRDATAVALID, LMMIREADY.
- Accepts single register read/write commands from the RISC-V peripheral bridge over a valid/ready command channel.
- Runs one LMMI transaction at a time and returns read data or a timeout error on a valid/ready response channel.
- Sits between the CPU bus bridge and the PLL instance. The PLL's LMMICLK is wired to the same clk_i.

Parameters:
- OFFSET_W, 7, LMMI offset width.
- DATA_W, 8, LMMI data width.
- TIMEOUT_CYCLES, 255, maximum cycles from request assertion to completion. 0 disables the timeout.
- ERR_RDATA, 8'hFF, rsp_rdata value returned on timeout.

Ports:
- clk_i  in  1  system clock; also drives PLL LMMICLK.
- rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_offset_i  in  OFFSET_W  register offset.
- cmd_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_W  read data (0 for writes).
- rsp_err_o  out  1  timeout occurred.
- lmmi_resetn_o  out  1  to LMMIRESET_N.
- lmmi_request_o  out  1  to LMMIREQUEST.
- lmmi_wrrd_n_o  out  1  to LMMIWRRD_N.
- lmmi_offset_o  out  OFFSET_W  to LMMIOFFSET.
- lmmi_wdata_o  out  DATA_W  to LMMIWDATA.
- lmmi_rdata_i  in  DATA_W  from LMMIRDATA.
- lmmi_rdata_valid_i  in  1  from LMMIRDATAVALID.
- lmmi_ready_i  in  1  from LMMIREADY.
- spurious_o  out  1  sticky: rdata_valid seen while no read outstanding.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - cmd_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - lmmi_request_o=0, lmmi_wrrd_n_o=0, lmmi_offset_o=0, lmmi_wdata_o=0.
  - lmmi_resetn_o=0, spurious_o=0.
  - State is IDLE, timeout counter is 0.
- lmmi_resetn_o is a registered copy of ~rst_i: it goes 1 one cycle after rst_i deasserts.
- IDLE state:
  - cmd_ready_o=1 (registered; 1 from the first cycle after reset).
  - On cmd_valid_i&cmd_ready_o: latch write/offset/wdata onto the lmmi_* outputs, assert lmmi_request_o next cycle, clear the counter, go to REQ.
  - cmd_ready_o drops in that same next cycle.
- REQ state:
  - lmmi_request_o, lmmi_wrrd_n_o, lmmi_offset_o and lmmi_wdata_o are held stable.
  - The counter increments every cycle.
  - Cycle with lmmi_ready_i=1 is the handshake. lmmi_request_o deasserts on the next edge.
  - Write at handshake: go to RSP with rdata=0, err=0.
  - Read at handshake with lmmi_rdata_valid_i=1 in the same cycle: capture lmmi_rdata_i, go to RSP.
  - Read at handshake otherwise: go to RDWAIT.
- RDWAIT state:
  - lmmi_request_o=0 and the counter keeps incrementing.
  - On lmmi_rdata_valid_i: capture lmmi_rdata_i, go to RSP.
- Timeout:
  - Applies in REQ or RDWAIT when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without completion.
  - lmmi_request_o deasserts, rsp_rdata_o=ERR_RDATA, rsp_err_o=1, go to RSP.
  - Completion and timeout in the same cycle: completion wins.
  - Counter width is clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- RSP state:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o&rsp_ready_i.
  - Then go to IDLE: rsp_valid_o=0 and cmd_ready_o=1 on the next cycle.
  - No new command is accepted while a response is pending.
- Minimum latency:
  - Write with lmmi_ready_i tied 1: command accept at cycle 0, request high in cycle 1, rsp_valid_o high in cycle 2.
  - Read with rdata_valid in the handshake cycle: same timing.
- Spurious detection:
  - lmmi_rdata_valid_i=1 in IDLE or RSP, or in REQ during a write, sets spurious_o.
  - The data is ignored and the state is unaffected.
  - spurious_o clears only on reset.
- Reset mid-operation: all state and outputs return to reset values at the next edge. lmmi_request_o drops and any in-flight response is discarded.
- cmd_* inputs are don't-care when cmd_ready_o=0. rsp_ready_i is don't-care when rsp_valid_o=0.

Decomposition:
- Shared package lmmi_pkg:
  - lmmi_state_t enum {IDLE, REQ, RDWAIT, RSP}.
  - Constants LMMI_OFFSET_W=7 and LMMI_DATA_W=8.
  - Defaults for ERR_RDATA and TIMEOUT_CYCLES.
- Single module, no sub-module. The timeout counter is inline.

Test Plan:
- Write offset 7'h12 data 8'hA5, LMMIREADY tied 1 → lmmi_request_o high exactly 1 cycle with wrrd_n=1, offset=12, wdata=A5. rsp_valid_o 2 cycles after accept with rdata=00, err=0.
- Read offset 7'h05, responder asserts ready after 3 cycles and rdata_valid 2 cycles later with 8'h3C → request held 4 cycles with stable offset. rsp_rdata_o=3C, err=0. cmd_ready_o returns 1 cycle after rsp handshake.
- Read with lmmi_ready_i never asserted, TIMEOUT_CYCLES=8 → request drops after 8 request cycles. rsp_err_o=1, rsp_rdata_o=FF. Next command is accepted normally.
- Response backpressure: rsp_ready_i low for 5 cycles after a read returning 8'h7E → rsp_valid_o and rsp_rdata_o=7E held stable. cmd_ready_o stays 0. No lmmi_request_o asserted.
- Pulse lmmi_rdata_valid_i in IDLE → spurious_o=1 next cycle and stays set. A following read still returns correct data.
- Assert rst_i during RDWAIT → next cycle all outputs at reset values, lmmi_resetn_o=0. lmmi_resetn_o=1 one cycle after rst_i deasserts.
